inv_response_checker: RTL
=========================

Name: inv_response_checker

Overview:
- Hardware checking end of the inverter stimulus/response interface.
- Accepts stimulus words as they are issued to a bitwise-inverter DUT, queues them as expected values, and checks each returned response word for resp_data == ~stim_data.
- Keeps pass/fail counts, a sticky error and the index of the first failure.
- Sits beside the GPU datapath as a self-test monitor; results are read over status ports.

Parameters:
DATA_W, 8, width of stimulus and response words
DEPTH, 4, expected-value FIFO depth (power of two, >= 2)
CNT_W, 16, width of vector and result counters

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous active-high reset
start  input  1  one-cycle pulse; begins a checking run
num_vectors  input  CNT_W  responses to check in this run; sampled on start
stim_valid  input  1  stimulus word valid
stim_ready  output  1  checker can accept stimulus word
stim_data  input  DATA_W  stimulus word sent to DUT
resp_valid  input  1  DUT response word valid (no backpressure)
resp_data  input  DATA_W  DUT response word
busy  output  1  state == RUN
done  output  1  state == DONE
pass_count  output  CNT_W  responses matching ~expected
fail_count  output  CNT_W  mismatches plus protocol errors
err_sticky  output  1  set on first fail; cleared only by start or rst
first_fail_idx  output  CNT_W  response index (0-based) of first fail
protocol_err  output  1  sticky: response with empty FIFO, or response outside RUN

Behaviour:
- Reset (rst high at clk edge): state IDLE; FIFO emptied; counters, err_sticky, first_fail_idx and protocol_err = 0; stim_ready = 0, busy = 0, done = 0.
- States:
  - IDLE: start -> RUN. Latch num_vectors; clear counters, flags and FIFO.
  - RUN: stim_ready = !fifo_full && (issued < num_vectors).
    - Stimulus handshake (stim_valid & stim_ready): push stim_data; issued++.
    - resp_valid with FIFO non-empty: pop the head; checked++.
      - If resp_data == ~head: pass_count++.
      - Else: fail_count++; if err_sticky was 0, set it and load first_fail_idx = checked (value before increment).
    - resp_valid with FIFO empty: fail_count++; protocol_err = 1; err_sticky set as above; checked not incremented.
    - checked reaching num_vectors -> DONE the next cycle.
    - num_vectors == 0 -> DONE the cycle after start.
  - DONE: done = 1, results held. start -> RUN with full clear, as from IDLE.
- start while in RUN is ignored.
- resp_valid in IDLE or DONE sets protocol_err only; counters are unchanged.
- FIFO rules:
  - Push and pop in the same cycle with FIFO non-empty: both occur; occupancy unchanged.
  - No bypass: a push into an empty FIFO is not visible to a same-cycle response, which is an underflow.
  - stim_ready is low when full, even if a pop occurs that cycle.
- Pointers: log2(DEPTH) bits plus a wrap bit for the full/empty distinction; wrap-around is seamless.
- Counters saturate at 2^CNT_W-1; no wrap.
- Latency: stimulus-to-check is 0 cycles beyond the response beat. Counters update at the edge after the response beat. done rises 1 cycle after the final check.
- rst mid-run: immediate return to IDLE with all state cleared; no partial results kept.

Test Plan:
- Good run: num_vectors=4; stim 0x00,0x0F,0xA5,0xFF; responses 0xFF,0xF0,0x5A,0x00 one cycle after each -> pass_count=4, fail_count=0, err_sticky=0, done=1.
- Mismatches: num_vectors=3; stim 0x12,0x34,0x56; responses 0xED,0x00,0xA8 -> pass=1, fail=2, err_sticky=1, first_fail_idx=1.
- Backpressure: DEPTH=4, 6 stim with stim_valid held and no responses -> stim_ready low after 4 pushes; then 1 response -> stim_ready high for 1 push; the remaining words drain with correct checks.
- Underflow/protocol: resp_valid in RUN with FIFO empty -> fail_count=1, protocol_err=1, first_fail_idx=0; resp_valid in IDLE -> protocol_err=1, counters stay 0.
- Boundaries: start with num_vectors=0 -> done the next cycle with counts 0. rst asserted mid-run after 2 checks -> IDLE, all outputs 0. A following start reruns cleanly.

Source files
------------

// File: rtl/inv_response_checker.sv
// Self-test monitor for a bitwise-inverter DUT: queues issued stimulus words and
// checks each returned response against the inverse of the oldest queued word.
module inv_response_checker #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [CNT_W-1:0]  num_vectors,
    input  logic              stim_valid,
    output logic              stim_ready,
    input  logic [DATA_W-1:0] stim_data,
    input  logic              resp_valid,
    input  logic [DATA_W-1:0] resp_data,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  pass_count,
    output logic [CNT_W-1:0]  fail_count,
    output logic              err_sticky,
    output logic [CNT_W-1:0]  first_fail_idx,
    output logic              protocol_err
);

    localparam int AW = $clog2(DEPTH);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [AW:0]      PTR_ONE = (AW + 1)'(1);

    logic [1:0]        state;
    logic [CNT_W-1:0]  target;
    logic [CNT_W-1:0]  issued;
    logic [CNT_W-1:0]  checked;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW:0]       wr_ptr;
    logic [AW:0]       rd_ptr;
    logic [DATA_W-1:0] head;
    logic              in_run;
    logic              fifo_empty;
    logic              fifo_full;
    logic              push;
    logic              pop;
    logic              launch;
    logic              resp_fail;
    logic              clear;

    assign in_run     = (state == S_RUN);
    assign busy       = in_run;
    assign done       = (state == S_DONE);
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign head       = mem[rd_ptr[AW-1:0]];

    // Ready depends on registered state only, so a same-cycle pop never re-opens a full FIFO.
    assign stim_ready = in_run && !fifo_full && (issued < target);
    assign push       = stim_valid && stim_ready;
    assign pop        = in_run && resp_valid && !fifo_empty;
    assign resp_fail  = in_run && resp_valid && (fifo_empty || (resp_data != ~head));
    assign launch     = start && !in_run;
    assign clear      = rst || launch;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= stim_data;
        end
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            state          <= rst ? S_IDLE : S_RUN;
            target         <= rst ? '0 : num_vectors;
            issued         <= '0;
            checked        <= '0;
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            pass_count     <= '0;
            fail_count     <= '0;
            err_sticky     <= 1'b0;
            first_fail_idx <= '0;
            protocol_err   <= 1'b0;
        end else begin
            // Completion is judged on the registered count, one cycle after the final check.
            if (in_run && (checked == target)) begin
                state <= S_DONE;
            end
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
                issued <= issued + CNT_ONE;
            end
            if (pop) begin
                rd_ptr  <= rd_ptr + PTR_ONE;
                checked <= checked + CNT_ONE;
                if (!resp_fail && (pass_count != CNT_MAX)) begin
                    pass_count <= pass_count + CNT_ONE;
                end
            end
            if (resp_fail) begin
                if (fail_count != CNT_MAX) begin
                    fail_count <= fail_count + CNT_ONE;
                end
                if (!err_sticky) begin
                    err_sticky     <= 1'b1;
                    first_fail_idx <= checked;
                end
            end
            if (resp_valid && (!in_run || fifo_empty)) begin
                protocol_err <= 1'b1;
            end
        end
    end

endmodule
